// File: rtl/mem_ctrl.sv
// Byte-serial controller for the 8-bit RAM/IO port: splits byte/half/word requests into
// little-endian byte accesses, pipelines reads against the one-cycle RAM latency.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [31:0] addr_q, wdata_q, rdata_q, a_q, d_a;
  logic [7:0]  dout_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [2:0]  n_q, cnt, cap_cnt;
  logic        a_live, d_live, wr_q, was_paused;

  logic [2:0]  req_n, w_idx;
  logic [31:0] w_base, w_data, w_addr, r_asm, r_ext, r_next_a;
  logic [7:0]  w_byte;
  logic        w_stall, replay;

  // Handshake: a request transfers on a rising edge where req_valid, req_ready and rdy_in
  // are all high; req_* are sampled only on that edge. resp_valid is a one-cycle pulse.
  always_comb begin
    req_n = 3'd4;
    if (req_size == 2'd0) req_n = 3'd1;
    else if (req_size == 2'd1) req_n = 3'd2;
    if (state == IDLE) begin
      w_base = req_addr;
      w_data = req_wdata;
      w_idx  = 3'd0;
    end else begin
      w_base = addr_q;
      w_data = wdata_q;
      w_idx  = cnt;
    end
    w_addr  = w_base + {29'd0, w_idx};
    w_byte  = w_data[{w_idx[1:0], 3'b000} +: 8];
    w_stall = (w_addr[17:16] == 2'b11) & io_buffer_full;
    r_next_a = addr_q + {29'd0, cnt};
    r_asm = rdata_q;
    r_asm[{cap_cnt[1:0], 3'b000} +: 8] = mem_din;
    case (size_q)
      2'd0:    r_ext = {{24{signed_q & r_asm[7]}}, r_asm[7:0]};
      2'd1:    r_ext = {{16{signed_q & r_asm[15]}}, r_asm[15:0]};
      default: r_ext = r_asm;
    endcase
  end

  // After a pause the byte whose data was due is re-addressed before capturing resumes.
  assign replay     = (state == READ) & was_paused & d_live;
  assign mem_a      = replay ? d_a : a_q;
  assign mem_dout   = dout_q;
  assign mem_wr     = wr_q & rdy_in & ~rst_in;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE) & rdy_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      addr_q <= '0; wdata_q <= '0; rdata_q <= '0; a_q <= '0; d_a <= '0;
      dout_q <= '0; size_q <= '0; signed_q <= 1'b0; n_q <= '0;
      cnt <= '0; cap_cnt <= '0;
      a_live <= 1'b0; d_live <= 1'b0; wr_q <= 1'b0; was_paused <= 1'b0;
      resp_rdata <= '0;
    end else begin
      was_paused <= ~rdy_in;
      if (rdy_in) begin
        case (state)
          IDLE: if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= req_size;
            signed_q <= req_signed;
            n_q      <= req_n;
            rdata_q  <= '0;
            cap_cnt  <= '0;
            d_live   <= 1'b0;
            a_q      <= req_addr;
            if (req_wr) begin
              state  <= WRITE;
              dout_q <= w_byte;
              wr_q   <= ~w_stall;
              cnt    <= w_stall ? 3'd0 : 3'd1;
            end else begin
              state  <= READ;
              a_live <= 1'b1;
              cnt    <= 3'd1;
            end
          end
          READ: if (!replay) begin
            if (d_live) begin
              rdata_q <= r_asm;
              cap_cnt <= cap_cnt + 3'd1;
              if (cap_cnt == n_q - 3'd1) begin
                state      <= DONE;
                resp_rdata <= r_ext;
              end
            end
            d_live <= a_live;
            d_a    <= a_q;
            if (cnt < n_q) begin
              a_q    <= r_next_a;
              a_live <= 1'b1;
              cnt    <= cnt + 3'd1;
            end else begin
              a_live <= 1'b0;
            end
          end
          WRITE: begin
            if (cnt == n_q) begin
              state      <= DONE;
              wr_q       <= 1'b0;
              resp_rdata <= '0;
            end else begin
              // a stalled IO byte keeps its address and is retried on the next edge
              a_q    <= w_addr;
              dout_q <= w_byte;
              wr_q   <= ~w_stall;
              if (!w_stall) cnt <= cnt + 3'd1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of load/store vectors with hand-computed latencies and
// data, plus sequences for pause/replay, IO back-pressure and reset during a store.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, req_valid, req_ready, req_wr, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_a;
  logic        resp_valid, mem_wr, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // RAM model (1 KiB, address aliased) and write monitor
  logic [7:0]  ram [0:1023];
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];
  always @(posedge clk_in) begin
    if (mem_wr) begin
      ram[mem_a[9:0]] <= mem_dout;
      obs_q.push_back({mem_a, mem_dout});
    end
    mem_din <= ram[mem_a[9:0]];
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs [0:14];

  logic [31:0] addr_tr [0:31];
  logic        wr_tr   [0:31];
  logic        rq_tr   [0:31];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [39:0] o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_extra_write got=%h exp=none", tag, o);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_write"}, o, e);
      end
    end
    chk({tag, "_missing_writes"}, 40'(exp_q.size()), 40'd0);
    exp_q.delete();
  endtask

  // driver: one request; pause/full/reset windows are given in cycles after the accept edge
  task automatic run_req(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int pause_at, input int pause_len, input int full_len,
                         input int rst_at, output int lat, output logic [31:0] rdata);
    int w;
    lat = 0;
    rdata = '0;
    w = 0;
    rdy_in = 1'b1;
    while (!req_ready && w < 10) begin
      @(negedge clk_in);
      w++;
    end
    chk("ready_before_req", {39'd0, req_ready}, 40'd1);
    req_valid = 1'b1;
    req_wr = wr;
    req_size = size;
    req_signed = sgn;
    req_addr = addr;
    req_wdata = wdata;
    io_buffer_full = (full_len > 0);
    @(posedge clk_in);
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) @(posedge clk_in);
      #1;
      req_valid = 1'b0;
      req_wr = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_addr = $urandom;
      req_wdata = $urandom;
      rdy_in = !(k >= pause_at && k < pause_at + pause_len);
      io_buffer_full = (k < full_len);
      rst_in = (k == rst_at);
      @(negedge clk_in);
      addr_tr[k] = mem_a;
      wr_tr[k] = mem_wr;
      rq_tr[k] = req_ready;
      if (resp_valid) begin
        lat = k;
        rdata = resp_rdata;
        break;
      end
    end
    rst_in = 1'b0;
    rdy_in = 1'b1;
    io_buffer_full = 1'b0;
  endtask

  initial begin
    int lat, n;
    logic [31:0] rd, a;
    logic [31:0] wd;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1234_5678, 5, 32'h0};
    vecs[1]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0200, 32'h0000_FF80, 3, 32'h0};
    vecs[2]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         6, 32'h1234_5678};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'h0,         3, 32'hFFFF_FF80};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0,         3, 32'h0000_0080};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'h0,         4, 32'hFFFF_FF80};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'h0,         4, 32'h0000_FF80};
    vecs[7]  = '{1'b0, 2'd3, 1'b1, 32'h0000_0100, 32'h0,         6, 32'h1234_5678};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_01FF, 32'hDEAD_BEEF, 5, 32'h0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_01FF, 32'h0,         6, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_5A3C, 3, 32'h0};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0,         4, 32'h0000_5A3C};
    vecs[12] = '{1'b1, 2'd0, 1'b0, 32'h0000_0300, 32'h1234_56A5, 2, 32'h0};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 32'h0000_0300, 32'h0,         3, 32'hFFFF_FFA5};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 32'h0000_0202, 32'h0,         3, 32'h0000_00DE};

    rst_in = 1'b1;
    rdy_in = 1'b1;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_size = 2'd0;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    io_buffer_full = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_req_ready", {39'd0, req_ready}, 40'd1);
    chk("rst_resp_valid", {39'd0, resp_valid}, 40'd0);
    chk("rst_resp_rdata", {8'd0, resp_rdata}, 40'd0);
    chk("rst_mem_a", {8'd0, mem_a}, 40'd0);
    chk("rst_mem_dout", {32'd0, mem_dout}, 40'd0);
    chk("rst_mem_wr", {39'd0, mem_wr}, 40'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);

    for (int i = 0; i <= 14; i++) begin
      n = (vecs[i].size == 2'd0) ? 1 : (vecs[i].size == 2'd1) ? 2 : 4;
      if (vecs[i].wr) begin
        wd = vecs[i].wdata;
        for (int j = 0; j < n; j++) begin
          a = vecs[i].addr + 32'(j);
          exp_q.push_back({a, wd[7:0]});
          wd = wd >> 8;
        end
      end
      run_req(vecs[i].wr, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
              0, 0, 0, 0, lat, rd);
      chk($sformatf("v%0d_latency", i), 40'(lat), 40'(vecs[i].lat));
      chk($sformatf("v%0d_rdata", i), {8'd0, rd}, {8'd0, vecs[i].rdata});
      if (!vecs[i].wr) begin
        for (int j = 0; j < n; j++) begin
          a = vecs[i].addr + 32'(j);
          chk($sformatf("v%0d_addr%0d", i, j), {8'd0, addr_tr[j + 1]}, {8'd0, a});
        end
      end
      check_writes($sformatf("v%0d", i));
    end

    // pause for 2 cycles after byte 1's address: replay of 0x101, response at T+9
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 2, 0, 0, lat, rd);
    chk("pause_latency", 40'(lat), 40'd9);
    chk("pause_rdata", {8'd0, rd}, {8'd0, 32'h1234_5678});
    chk("pause_addr_t2", {8'd0, addr_tr[2]}, {8'd0, 32'h101});
    chk("pause_replay_addr", {8'd0, addr_tr[5]}, {8'd0, 32'h101});
    chk("pause_resume_addr", {8'd0, addr_tr[6]}, {8'd0, 32'h102});
    check_writes("pause");

    // IO store held off by a full UART buffer for 3 issue edges
    exp_q.push_back({32'h0003_0000, 8'h41});
    run_req(1'b1, 2'd0, 1'b0, 32'h0003_0000, 32'h0000_0041, 0, 0, 3, 0, lat, rd);
    chk("io_latency", 40'(lat), 40'd5);
    chk("io_stall_wr1", {39'd0, wr_tr[1]}, 40'd0);
    chk("io_stall_wr2", {39'd0, wr_tr[2]}, 40'd0);
    chk("io_stall_wr3", {39'd0, wr_tr[3]}, 40'd0);
    chk("io_write_wr4", {39'd0, wr_tr[4]}, 40'd1);
    chk("io_write_addr", {8'd0, addr_tr[4]}, {8'd0, 32'h0003_0000});
    check_writes("io");

    // RAM-space store is not affected by io_buffer_full
    exp_q.push_back({32'h0000_0310, 8'h5C});
    run_req(1'b1, 2'd0, 1'b0, 32'h310, 32'h0000_005C, 0, 0, 3, 0, lat, rd);
    chk("ramfull_latency", 40'(lat), 40'd2);
    chk("ramfull_wr1", {39'd0, wr_tr[1]}, 40'd1);
    check_writes("ramfull");

    // reset in T+2 of a word store: only addr+0 is written, no response
    exp_q.push_back({32'h0000_0100, 8'h44});
    run_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344, 0, 0, 0, 2, lat, rd);
    chk("rst_store_no_resp", 40'(lat), 40'd0);
    chk("rst_store_wr1", {39'd0, wr_tr[1]}, 40'd1);
    chk("rst_store_wr2", {39'd0, wr_tr[2]}, 40'd0);
    chk("rst_store_wr3", {39'd0, wr_tr[3]}, 40'd0);
    chk("rst_store_ready3", {39'd0, rq_tr[3]}, 40'd1);
    chk("rst_store_ram0", {32'd0, ram[10'h100]}, {32'd0, 8'h44});
    chk("rst_store_ram1", {32'd0, ram[10'h101]}, {32'd0, 8'h56});
    check_writes("rst_store");

    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 0, 0, 0, lat, rd);
    chk("post_rst_latency", 40'(lat), 40'd6);
    chk("post_rst_rdata", {8'd0, rd}, {8'd0, 32'h1234_5644});
    @(negedge clk_in);
    chk("resp_single_pulse", {39'd0, resp_valid}, 40'd0);
    check_writes("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
